// File: rtl/ysyx_24110006_axi_pkg.sv
// Shared AXI response/burst encodings and the controller state type for the
// on-chip SRAM responder.
package ysyx_24110006_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RWAIT,
        ST_RDATA,
        ST_WCOLLECT,
        ST_WDRAIN,
        ST_WWAIT,
        ST_WRESP
    } state_t;

endpackage

// File: rtl/ysyx_24110006_sram_array.sv
// Word-organised storage: combinational read port, synchronous byte-enabled
// write port. Contents are never reset.
module ysyx_24110006_sram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       be
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ysyx_24110006_axi_sram.sv
// AXI4 responder in front of the SRAM array: one transaction at a time,
// single-beat writes, FIXED/INCR read bursts, fixed response latencies.
module ysyx_24110006_axi_sram
    import ysyx_24110006_axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arid,
    input  logic [7:0]  i_axi_arlen,
    input  logic [2:0]  i_axi_arsize,
    input  logic [1:0]  i_axi_arburst,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    output logic [1:0]  o_axi_rresp,
    input  logic        i_axi_rready,
    output logic        o_axi_rlast,
    output logic [3:0]  o_axi_rid,
    input  logic [31:0] i_axi_awaddr,
    input  logic        i_axi_awvalid,
    output logic        o_axi_awready,
    input  logic [3:0]  i_axi_awid,
    input  logic [7:0]  i_axi_awlen,
    input  logic [2:0]  i_axi_awsize,
    input  logic [1:0]  i_axi_awburst,
    input  logic [31:0] i_axi_wdata,
    input  logic [3:0]  i_axi_wstrb,
    input  logic        i_axi_wvalid,
    output logic        o_axi_wready,
    input  logic        i_axi_wlast,
    output logic [1:0]  o_axi_bresp,
    output logic        o_axi_bvalid,
    input  logic        i_axi_bready,
    output logic [3:0]  o_axi_bid
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [15:0] cnt;

    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len, beat;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;

    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        aw_got, w_got;
    logic [1:0]  b_resp;

    logic        ar_hs, aw_hs, w_hs, have_aw, have_w;
    logic [7:0]  len_now;
    logic [31:0] r_off, w_off;
    logic        r_ok, w_err, mem_we;
    logic [31:0] mem_rdata;
    logic        unused;

    // Write-only burst attributes carry no information for single-beat writes.
    assign unused = ^{i_axi_awsize, i_axi_awburst};

    assign ar_hs   = i_axi_arvalid & o_axi_arready;
    assign aw_hs   = i_axi_awvalid & o_axi_awready;
    assign w_hs    = i_axi_wvalid  & o_axi_wready;
    assign have_aw = aw_got | aw_hs;
    assign have_w  = w_got  | w_hs;
    assign len_now = aw_hs ? i_axi_awlen : aw_len;

    // Unsigned offset wraps below ADDR_BASE, so one compare covers both bounds.
    assign r_off = ar_addr - ADDR_BASE;
    assign r_ok  = r_off < SPAN;
    assign w_off = aw_addr - ADDR_BASE;
    assign w_err = (w_off >= SPAN) || (aw_len != 8'd0);

    always_comb begin
        state_nxt     = state;
        o_axi_arready = 1'b0;
        o_axi_awready = 1'b0;
        o_axi_wready  = 1'b0;
        if (!i_reset) begin
            case (state)
                ST_IDLE: begin
                    o_axi_arready = 1'b1;
                    o_axi_awready = !i_axi_arvalid;
                    o_axi_wready  = !i_axi_arvalid;
                end
                ST_WCOLLECT: begin
                    o_axi_awready = !aw_got;
                    o_axi_wready  = !w_got;
                end
                ST_WDRAIN: o_axi_wready = 1'b1;
                default: ;
            endcase
        end
        case (state)
            ST_IDLE: begin
                if (ar_hs)                                     state_nxt = ST_RWAIT;
                else if (aw_hs && w_hs && i_axi_awlen == 8'd0) state_nxt = ST_WWAIT;
                else if (aw_hs || w_hs)                        state_nxt = ST_WCOLLECT;
            end
            ST_RWAIT:    if (cnt == 16'd0) state_nxt = ST_RDATA;
            ST_RDATA:    if (i_axi_rready && beat == ar_len) state_nxt = ST_IDLE;
            ST_WCOLLECT: if (have_aw && have_w) state_nxt = (len_now == 8'd0) ? ST_WWAIT : ST_WDRAIN;
            ST_WDRAIN:   if (w_hs && i_axi_wlast) state_nxt = ST_WWAIT;
            ST_WWAIT:    if (cnt == 16'd0) state_nxt = ST_WRESP;
            ST_WRESP:    if (i_axi_bready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ar_addr  <= '0;
            ar_id    <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            beat     <= '0;
            aw_addr  <= '0;
            aw_id    <= '0;
            aw_len   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                ar_addr  <= i_axi_araddr;
                ar_id    <= i_axi_arid;
                ar_len   <= i_axi_arlen;
                ar_size  <= i_axi_arsize;
                ar_burst <= i_axi_arburst;
                beat     <= '0;
                cnt      <= 16'(RD_LAT - 1);
            end
            if (aw_hs) begin
                aw_addr <= i_axi_awaddr;
                aw_id   <= i_axi_awid;
                aw_len  <= i_axi_awlen;
                aw_got  <= 1'b1;
            end
            if (w_hs && state != ST_WDRAIN) begin
                w_data <= i_axi_wdata;
                w_strb <= i_axi_wstrb;
                w_got  <= 1'b1;
            end
            if ((state == ST_RWAIT || state == ST_WWAIT) && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end
            if (state == ST_RDATA && i_axi_rready) begin
                beat <= beat + 8'd1;
                case (ar_burst)
                    BURST_FIXED: ar_addr <= ar_addr;
                    BURST_INCR, BURST_WRAP: ar_addr <= ar_addr + (32'd1 << ar_size);
                    default: ar_addr <= ar_addr + (32'd1 << ar_size);
                endcase
            end
            // Flags are cleared after the capture above so entry into WWAIT wins.
            if (state_nxt == ST_WWAIT && state != ST_WWAIT) begin
                cnt    <= 16'(WR_LAT - 1);
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (state == ST_WWAIT && cnt == 16'd0) begin
                b_resp <= w_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign mem_we = (state == ST_WWAIT) && (cnt == 16'd0) && !w_err && !i_reset;

    ysyx_24110006_sram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk  (i_clock),
        .raddr(r_off[IDX_W+1:2]),
        .rdata(mem_rdata),
        .we   (mem_we),
        .waddr(w_off[IDX_W+1:2]),
        .wdata(w_data),
        .be   (w_strb)
    );

    assign o_axi_rvalid = (state == ST_RDATA);
    assign o_axi_rdata  = (o_axi_rvalid && r_ok) ? mem_rdata : '0;
    assign o_axi_rresp  = (o_axi_rvalid && !r_ok) ? RESP_SLVERR : RESP_OKAY;
    assign o_axi_rlast  = o_axi_rvalid && (beat == ar_len);
    assign o_axi_rid    = ar_id;

    assign o_axi_bvalid = (state == ST_WRESP);
    assign o_axi_bresp  = b_resp;
    assign o_axi_bid    = aw_id;

endmodule
